// File: rtl/wb_uart_master_if.sv
// Host byte stream and Wishbone initiator signal bundle.
interface wb_uart_master_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_stall_i;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  wbm_stall_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    output wbm_stall_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/wb_uart_master.sv
// Host packet parser that runs one pipelined Wishbone
// transaction per command and streams back a status response.
module wb_uart_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              wb_clk_i,
  input logic              rst_i,
  wb_uart_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_WR = 8'h57;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [2:0]    left;
  logic [31:0]   rdata;
  logic [TW-1:0] tmo;

  logic rx_fire;
  logic tx_fire;
  logic is_cmd;
  logic done;
  logic fin;
  logic go;
  logic tmo_hit;

  assign bus.wbm_sel_o = 4'hF;

  assign rx_fire = bus.rx_valid_i & bus.rx_ready_o;
  assign tx_fire = bus.tx_valid_o & bus.tx_ready_i;
  assign is_cmd  = (bus.rx_data_i == OP_RD) |
                   (bus.rx_data_i == OP_WR);
  assign done    = bus.wbm_ack_i | bus.wbm_err_i;
  // ack/err only count once the strobe has been taken
  assign fin     = done & ((state == BUS_WAIT) |
                           ~bus.wbm_stall_i);
  assign go      = (state == BUS_REQ) & ~bus.wbm_stall_i;
  assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      left           <= '0;
      rdata          <= '0;
      tmo            <= '0;
      bus.rx_ready_o <= 1'b1;
      bus.tx_valid_o <= 1'b0;
      bus.tx_data_o  <= '0;
      bus.wbm_cyc_o  <= 1'b0;
      bus.wbm_stb_o  <= 1'b0;
      bus.wbm_we_o   <= 1'b0;
      bus.wbm_adr_o  <= '0;
      bus.wbm_dat_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            cnt <= '0;
            if (is_cmd) begin
              state        <= ADDR;
              bus.wbm_we_o <= bus.rx_data_i == OP_WR;
            end else begin
              state          <= RESP;
              bus.rx_ready_o <= 1'b0;
              bus.tx_valid_o <= 1'b1;
              bus.tx_data_o  <= 8'h3F;
              left           <= '0;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            bus.wbm_adr_o <= {bus.wbm_adr_o[23:0],
                              bus.rx_data_i};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (bus.wbm_we_o) begin
                state <= DATA;
              end else begin
                state          <= BUS_REQ;
                bus.wbm_cyc_o  <= 1'b1;
                bus.wbm_stb_o  <= 1'b1;
                bus.rx_ready_o <= 1'b0;
                tmo            <= '0;
              end
            end
          end
        end
        DATA: begin
          if (rx_fire) begin
            bus.wbm_dat_o <= {bus.wbm_dat_o[23:0],
                              bus.rx_data_i};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state          <= BUS_REQ;
              bus.wbm_cyc_o  <= 1'b1;
              bus.wbm_stb_o  <= 1'b1;
              bus.rx_ready_o <= 1'b0;
              tmo            <= '0;
            end
          end
        end
        BUS_REQ, BUS_WAIT: begin
          if (tmo != TW'(TIMEOUT_CYCLES))
            tmo <= tmo + TW'(1);
          // a response landing on the last cycle beats the timeout
          if (fin) begin
            state          <= RESP;
            bus.wbm_cyc_o  <= 1'b0;
            bus.wbm_stb_o  <= 1'b0;
            bus.tx_valid_o <= 1'b1;
            bus.tx_data_o  <= bus.wbm_err_i ? 8'h15 : 8'h06;
            left           <= (!bus.wbm_err_i &&
                               !bus.wbm_we_o) ? 3'd4 : 3'd0;
            rdata          <= bus.wbm_dat_i;
          end else if (tmo_hit) begin
            state          <= RESP;
            bus.wbm_cyc_o  <= 1'b0;
            bus.wbm_stb_o  <= 1'b0;
            bus.tx_valid_o <= 1'b1;
            bus.tx_data_o  <= 8'h18;
            left           <= '0;
          end else if (go) begin
            state         <= BUS_WAIT;
            bus.wbm_stb_o <= 1'b0;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (left == 3'd0) begin
              state          <= IDLE;
              bus.tx_valid_o <= 1'b0;
              bus.rx_ready_o <= 1'b1;
            end else begin
              bus.tx_data_o <= rdata[31:24];
              rdata         <= {rdata[23:0], 8'h00};
              left          <= left - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_uart_master.sv
// Bench for wb_uart_master: packet table, corner sequences
// and random packets against a response model.
module tb_wb_uart_master;
  localparam int TMO = 16;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rd;
    int          stall;
    int          dly;
    bit          err;
    bit          both;
    bit          never;
    bit          late;
    int          txm;
    int          nexp;
    logic [39:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  wb_uart_master_if bus();

  wb_uart_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk),
    .rst_i   (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // slave/host configuration, written by the test process only
  int          s_stall;
  int          s_dly;
  bit          s_err;
  bit          s_both;
  bit          s_never;
  bit          s_late;
  logic [31:0] s_rd;
  int          tx_mode;

  // observation state, written by the monitor processes only
  int         stall_left;
  int         pend;
  bit         prev_cyc;
  bit         tgl;
  int         stb_cnt;
  int         cyc_cnt;
  acc_t       acc_q[$];
  int         rise_q[$];
  int         tvq[$];
  logic [7:0] got[$];

  int n_tests = 0;
  int n_fail = 0;
  int last_acc;
  int b_acc, b_got, b_stb, b_cyc, b_tv, b_rise;

  task automatic slave_reply;
    if (s_err) begin
      bus.wbm_err_i = 1'b1;
      bus.wbm_ack_i = s_both;
    end else begin
      bus.wbm_ack_i = 1'b1;
    end
    bus.wbm_dat_i = s_rd;
  endtask

  always @(negedge clk) begin
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_err_i   = 1'b0;
    bus.wbm_stall_i = 1'b0;
    bus.wbm_dat_i   = $urandom;
    if (bus.wbm_cyc_o === 1'b1 && !prev_cyc) begin
      rise_q.push_back(cyc_n);
      stall_left = s_stall;
      pend = 0;
    end
    if (bus.wbm_cyc_o !== 1'b1 && prev_cyc && s_late)
      bus.wbm_ack_i = 1'b1;
    prev_cyc = bus.wbm_cyc_o === 1'b1;
    if (bus.wbm_cyc_o === 1'b1) cyc_cnt++;
    if (bus.wbm_stb_o === 1'b1) stb_cnt++;
    if (pend > 0) begin
      pend--;
      if (pend == 0) slave_reply();
    end
    if (bus.wbm_cyc_o === 1'b1 && bus.wbm_stb_o === 1'b1) begin
      if (stall_left > 0) begin
        bus.wbm_stall_i = 1'b1;
        stall_left--;
      end else begin
        acc_q.push_back('{bus.wbm_adr_o, bus.wbm_dat_o,
                          bus.wbm_we_o, bus.wbm_sel_o});
        if (!s_never) begin
          if (s_dly == 0) slave_reply();
          else pend = s_dly;
        end
      end
    end
  end

  always @(negedge clk) begin
    tgl = ~tgl;
    case (tx_mode)
      0:       bus.tx_ready_i = 1'b1;
      1:       bus.tx_ready_i = tgl;
      default: bus.tx_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (bus.tx_valid_o === 1'b1) begin
      tvq.push_back(cyc_n);
      if (bus.tx_ready_i) got.push_back(bus.tx_data_o);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic vec_t mk(
    logic [7:0] op, logic [31:0] adr, logic [31:0] dat,
    logic [31:0] rd, int stall, int dly, bit err, bit both,
    bit never, bit late, int txm, int nexp, logic [39:0] exp);
    vec_t v;
    v.op = op; v.adr = adr; v.dat = dat; v.rd = rd;
    v.stall = stall; v.dly = dly; v.err = err;
    v.both = both; v.never = never; v.late = late;
    v.txm = txm; v.nexp = nexp; v.exp = exp;
    return v;
  endfunction

  function automatic bit is_cmd(logic [7:0] op);
    return op == 8'h52 || op == 8'h57;
  endfunction

  // response stream predicted from the packet and slave behaviour
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    if (!is_cmd(v.op)) begin
      r.nexp = 1; r.exp = {8'h3F, 32'h0};
    end else if (v.never) begin
      r.nexp = 1; r.exp = {8'h18, 32'h0};
    end else if (v.err) begin
      r.nexp = 1; r.exp = {8'h15, 32'h0};
    end else if (v.op == 8'h57) begin
      r.nexp = 1; r.exp = {8'h06, 32'h0};
    end else begin
      r.nexp = 5; r.exp = {8'h06, v.rd};
    end
    return r;
  endfunction

  task automatic put_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    while (bus.rx_ready_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) expire("rx_accept");
    last_acc = cyc_n;
  endtask

  task automatic send_vec(input vec_t v);
    put_byte(v.op);
    if (is_cmd(v.op))
      for (int i = 0; i < 4; i++) put_byte(v.adr[31-8*i -: 8]);
    if (v.op == 8'h57)
      for (int i = 0; i < 4; i++) put_byte(v.dat[31-8*i -: 8]);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input string nm);
    int n = 0;
    int ng;
    int exp_cyc;
    acc_t a;
    s_stall = v.stall; s_dly = v.dly; s_err = v.err;
    s_both = v.both; s_never = v.never; s_late = v.late;
    s_rd = v.rd; tx_mode = v.txm;
    b_acc = acc_q.size(); b_got = got.size();
    b_stb = stb_cnt; b_cyc = cyc_cnt;
    b_tv = tvq.size(); b_rise = rise_q.size();
    send_vec(v);
    while (!(bus.rx_ready_o === 1'b1 &&
             bus.tx_valid_o === 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) expire({nm, " idle"});
    repeat (2) @(negedge clk);
    ng = got.size() - b_got;
    chk({nm, " nbytes"}, ng, v.nexp);
    for (int i = 0; i < v.nexp && i < ng; i++)
      chk($sformatf("%s byte%0d", nm, i), got[b_got+i],
          v.exp[39-8*i -: 8]);
    chk({nm, " ntxn"}, acc_q.size() - b_acc,
        is_cmd(v.op) ? 1 : 0);
    if (acc_q.size() > b_acc) begin
      a = acc_q[b_acc];
      chk({nm, " adr"}, a.adr, v.adr);
      chk({nm, " we"}, a.we, v.op == 8'h57);
      chk({nm, " sel"}, a.sel, 4'hF);
      if (v.op == 8'h57) chk({nm, " dat"}, a.dat, v.dat);
    end
    exp_cyc = !is_cmd(v.op) ? 0 :
              v.never ? TMO : v.stall + 1 + v.dly;
    chk({nm, " stb_cycles"}, stb_cnt - b_stb,
        is_cmd(v.op) ? v.stall + 1 : 0);
    chk({nm, " cyc_cycles"}, cyc_cnt - b_cyc, exp_cyc);
  endtask

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tx_mode = 0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst ctl", {bus.wbm_cyc_o, bus.wbm_stb_o,
                    bus.wbm_we_o, bus.tx_valid_o,
                    bus.rx_ready_o, bus.wbm_sel_o},
        9'b0_0001_1111);
    chk("rst adr", bus.wbm_adr_o, 32'h0);
    chk("rst dat", bus.wbm_dat_o, 32'h0);
    chk("rst txd", bus.tx_data_o, 8'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = mk(8'h57, 32'h01000010, 32'hDEADBEEF, 32'h0,
                0, 1, 0, 0, 0, 0, 0, 1, 40'h06_0000_0000);
    tbl[1] = mk(8'h52, 32'h02000004, 32'h0, 32'h000000A5,
                0, 1, 0, 0, 0, 0, 0, 5, 40'h06_0000_00A5);
    tbl[2] = mk(8'h57, 32'h00000100, 32'h11223344, 32'h0,
                3, 1, 0, 0, 0, 0, 0, 1, 40'h06_0000_0000);
    tbl[3] = mk(8'h52, 32'h00000200, 32'h0, 32'h0000FFFF,
                0, 1, 0, 0, 1, 1, 0, 1, 40'h18_0000_0000);
    tbl[4] = mk(8'h52, 32'h00000300, 32'h0, 32'h12345678,
                0, 2, 0, 0, 0, 0, 0, 5, 40'h06_1234_5678);
    tbl[5] = mk(8'h57, 32'h00000400, 32'h55AA55AA, 32'h0,
                0, 1, 1, 0, 0, 0, 0, 1, 40'h15_0000_0000);
    tbl[6] = mk(8'h00, 32'h0, 32'h0, 32'h0,
                0, 1, 0, 0, 0, 0, 0, 1, 40'h3F_0000_0000);
    tbl[7] = mk(8'h52, 32'h00000500, 32'h0, 32'hCAFEF00D,
                0, 1, 0, 0, 0, 0, 1, 5, 40'h06_CAFE_F00D);
    tbl[8] = mk(8'h52, 32'h00000600, 32'h0, 32'h00000001,
                1, 0, 1, 1, 0, 0, 0, 1, 40'h15_0000_0000);
    tbl[9] = mk(8'h57, 32'hFFFFFFFC, 32'h0BADF00D, 32'h0,
                0, 0, 0, 0, 0, 0, 2, 1, 40'h06_0000_0000);

    for (int i = 0; i < 10; i++)
      run_case(tbl[i], $sformatf("vec%0d", i));

    // zero-wait read: bus start, response latency, burst length
    run_case(mk(8'h52, 32'h00000700, 32'h0, 32'h89ABCDEF,
                0, 1, 0, 0, 0, 0, 0, 5, 40'h06_89AB_CDEF),
             "lat");
    chk("lat cyc_rise",
        rise_q.size() > b_rise ? rise_q[b_rise] - last_acc : -1,
        1);
    chk("lat tx_valid",
        tvq.size() > b_tv ? tvq[b_tv] - last_acc : -1, 3);
    chk("lat tx_cycles", tvq.size() - b_tv, 5);
    chk("lat tx_span",
        tvq.size() > b_tv + 4 ? tvq[b_tv+4] - tvq[b_tv] : -1, 4);

    // reset dropped while the slave is silent in the wait phase
    s_never = 1; s_late = 0; s_stall = 0; s_err = 0;
    tx_mode = 0;
    send_vec(mk(8'h52, 32'h00000800, 32'h0, 32'h0,
                0, 1, 0, 0, 1, 0, 0, 1, 40'h0));
    n = 0;
    while (!(bus.wbm_cyc_o === 1'b1 &&
             bus.wbm_stb_o === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) expire("bus_wait entry");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst cyc", bus.wbm_cyc_o, 1'b0);
    chk("async rst stb", bus.wbm_stb_o, 1'b0);
    chk("async rst rx_ready", bus.rx_ready_o, 1'b1);
    chk("async rst tx_valid", bus.tx_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case(mk(8'h52, 32'h00000900, 32'h0, 32'h0F1E2D3C,
                0, 1, 0, 0, 0, 0, 0, 5, 40'h06_0F1E_2D3C),
             "post_rst");

    for (int k = 0; k < 60; k++) begin
      vec_t v;
      logic [7:0] o;
      int pick;
      pick = $urandom_range(0, 9);
      o = 8'($urandom);
      if (is_cmd(o)) o = 8'h00;
      v.op = pick < 4 ? 8'h52 : pick < 8 ? 8'h57 : o;
      v.adr = $urandom;
      v.dat = $urandom;
      v.rd = $urandom;
      v.stall = $urandom_range(0, 3);
      v.dly = $urandom_range(0, 3);
      v.err = $urandom_range(0, 4) == 0;
      v.both = 1'($urandom_range(0, 1));
      v.never = $urandom_range(0, 9) == 0;
      v.late = 1'b0;
      v.txm = $urandom_range(0, 2);
      v = model(v);
      run_case(v, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
